// File: rtl/seq_divider_pkg.sv
// Shared encodings and default widths for the shift-add multiplier / restoring divider pair.
// Both datapaths use the same three-state IDLE/RUN/DONE sequencing.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// then subtract the divisor when it fits.
module div_restore_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   p,
    input  logic                 q_msb,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   p_next,
    output logic                 q_bit
);

    // One spare bit above p so the shifted value is never truncated before the compare.
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] dvs_ext;

    always_comb begin
        shifted = {p, q_msb};
        dvs_ext = {2'b00, divisor};
        q_bit   = (shifted >= dvs_ext);
        p_next  = (DIVISOR_W+1)'(q_bit ? (shifted - dvs_ext) : shifted);
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Handshake: start is sampled only in IDLE; done is a one-cycle pulse per accepted op.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    state_t                state_q, state_d;
    logic [DIVISOR_W:0]    p_q;
    logic [DIVIDEND_W-1:0] q_q;
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DIVISOR_W:0]    p_next;
    logic                  q_bit;
    logic [DIVIDEND_W-1:0] q_shift;

    div_restore_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .p       (p_q),
        .q_msb   (q_q[DIVIDEND_W-1]),
        .divisor (divisor_q),
        .p_next  (p_next),
        .q_bit   (q_bit)
    );

    assign q_shift = {q_q[DIVIDEND_W-2:0], q_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (divisor == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // Result registers are written only on the edge entering DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q       <= '0;
            q_q       <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        divisor_q <= divisor;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b1;
                        end else begin
                            p_q   <= '0;
                            q_q   <= dividend;
                            cnt_q <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    p_q   <= p_next;
                    q_q   <= q_shift;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        quotient  <= q_shift;
                        remainder <= p_next[DIVISOR_W-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases, reset abort, exhaustive and random operand sweeps
// against an arithmetic reference (a / b, a % b).
module tb_seq_divider;

    localparam int DW = 8;
    localparam int SW = 4;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_zero;
    logic          busy;
    logic          done;

    int n_vec;
    int n_err;
    int ops_done;
    int done_seen;
    logic [DW-1:0] last_q;
    logic [SW-1:0] last_r;
    logic          last_z;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .busy      (busy),
        .done      (done)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drives one operation from IDLE, follows it to DONE and back to IDLE.
    task automatic run_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input bit poke);
        int lat;
        logic [DW-1:0] eq;
        logic [SW-1:0] er;
        logic          ez;
        if (b == 0) begin
            eq = '1; er = '0; ez = 1'b1;
        end else begin
            eq = DW'(int'(a) / int'(b));
            er = SW'(int'(a) % int'(b));
            ez = 1'b0;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            check("busy_run", 32'(busy), 32'd1);
            check("hold_q", 32'(quotient), 32'(last_q));
            check("hold_r", 32'(remainder), 32'(last_r));
            check("hold_z", 32'(div_zero), 32'(last_z));
            if (poke && lat == 2) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", 32'(lat), (b == 0) ? 32'd0 : 32'(DW));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_zero", 32'(div_zero), 32'(ez));
        check("busy_done", 32'(busy), 32'd1);
        if (b != 0) begin
            check("invariant", 32'(int'(quotient) * int'(b) + int'(remainder)), 32'(a));
            check("rem_lt_div", 32'(remainder < b), 32'd1);
        end
        ops_done++;
        last_q = eq;
        last_r = er;
        last_z = ez;
        @(posedge clk); #1;
        check("done_1cy", 32'(done), 32'd0);
        check("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; ops_done = 0; done_seen = 0;
        last_q = '0; last_r = '0; last_z = 1'b0;
        start = 1'b0; dividend = '0; divisor = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_z", 32'(div_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'd200, 4'd7, 1'b0);
        run_op(8'd255, 4'd1, 1'b0);
        run_op(8'd255, 4'd15, 1'b0);
        run_op(8'd5, 4'd9, 1'b0);
        run_op(8'd100, 4'd0, 1'b0);
        run_op(8'd50, 4'd5, 1'b0);
        run_op(8'd200, 4'd7, 1'b1);

        // abort mid-run: start 200/7, reset on the fourth RUN cycle
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        check("abort_z", 32'(div_zero), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        last_q = '0; last_r = '0; last_z = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_seen), 32'(ops_done));
        run_op(8'd13, 4'd4, 1'b0);

        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                run_op(DW'(a), SW'(b), 1'b0);

        for (int i = 0; i < 300; i++)
            run_op(DW'($urandom_range(255, 0)), SW'($urandom_range(15, 0)),
                   bit'($urandom_range(1, 0)));

        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_seen), 32'(ops_done));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
